// File: rtl/dca_matrix_store_pkg.sv
// dca_matrix_store_pkg: FSM state encoding, AXI OKAY code and beat sizing helpers for the matrix row store
package dca_matrix_store_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_RESP, S_DONE} state_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    function automatic int BYTES_PER_BEAT(input int bw_axi_data);
        return bw_axi_data / 8;
    endfunction
    function automatic int BEATS_PER_ROW_MAX(input int num_col, input int bw_element, input int bw_axi_data);
        return (num_col * bw_element) / bw_axi_data;
    endfunction
endpackage

// File: rtl/dca_matrix_store_beat_slicer.sv
// dca_matrix_store_beat_slicer: selects beat beat_cnt of the row buffer and strobes only the bytes still inside row_bytes
//   row_buf   in  buffered tensor row, element 0 in the LSBs
//   beat_cnt  in  beat index within the row
//   row_bytes in  valid bytes in the row
//   wdata     out beat data
//   wstrb     out byte strobes
module dca_matrix_store_beat_slicer
    import dca_matrix_store_pkg::*;
#(
    parameter int BW_AXI_DATA  = 32,
    parameter int BW_ROW       = 128,
    parameter int BW_BEAT_CNT  = 3,
    parameter int BW_ROW_BYTES = 5
) (
    input  logic [BW_ROW-1:0]        row_buf,
    input  logic [BW_BEAT_CNT-1:0]   beat_cnt,
    input  logic [BW_ROW_BYTES-1:0]  row_bytes,
    output logic [BW_AXI_DATA-1:0]   wdata,
    output logic [BW_AXI_DATA/8-1:0] wstrb
);
    localparam int BPB = BYTES_PER_BEAT(BW_AXI_DATA);
    int rem;
    int n_bytes;
    // a shift rather than a part-select keeps an out-of-range beat_cnt (after the final beat) at zero
    always_comb begin
        rem     = int'(row_bytes) - int'(beat_cnt) * BPB;
        n_bytes = rem <= 0 ? 0 : (rem >= BPB ? BPB : rem);
        wdata   = BW_AXI_DATA'(row_buf >> (int'(beat_cnt) * BW_AXI_DATA));
        wstrb   = ~({BPB{1'b1}} << n_bytes);
    end
endmodule

// File: rtl/dca_matrix_row_store.sv
// dca_matrix_row_store: accepts a store command, then slices each tensor row into AXI write-data beats with strobes
//   clk, rst (async, active-high)
//   cmd_valid/cmd_ready, cmd_num_row, cmd_num_col   store command (num_col 0 means NUM_COL)
//   row_valid/row_ready, row_data                   tensor rows from the compute array
//   wvalid/wready, wdata, wstrb, wlast              AXI write-data channel
//   bvalid/bready, bresp                            AXI write-response channel
//   done_valid, done_error, busy                    completion pulse and status
// Define DCA_MATRIX_STORE_BRESP_EN to wait for the write response before completing.
module dca_matrix_row_store
    import dca_matrix_store_pkg::*;
#(
    parameter  int BW_AXI_DATA = 32,
    parameter  int BW_ELEMENT  = 32,
    parameter  int NUM_COL     = 4,
    parameter  int BW_NUM_ROW  = 8,
    localparam int BW_ROW      = NUM_COL * BW_ELEMENT,
    localparam int BW_COL      = $clog2(NUM_COL) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [BW_NUM_ROW-1:0]    cmd_num_row,
    input  logic [BW_COL-1:0]        cmd_num_col,
    input  logic                     row_valid,
    output logic                     row_ready,
    input  logic [BW_ROW-1:0]        row_data,
    output logic                     wvalid,
    input  logic                     wready,
    output logic [BW_AXI_DATA-1:0]   wdata,
    output logic [BW_AXI_DATA/8-1:0] wstrb,
    output logic                     wlast,
    input  logic                     bvalid,
    output logic                     bready,
    input  logic [1:0]               bresp,
    output logic                     done_valid,
    output logic                     done_error,
    output logic                     busy
);
    localparam int BPB          = BYTES_PER_BEAT(BW_AXI_DATA);
    localparam int BEATS_MAX    = BEATS_PER_ROW_MAX(NUM_COL, BW_ELEMENT, BW_AXI_DATA);
    localparam int BW_BEAT_CNT  = $clog2(BEATS_MAX + 1);
    localparam int BW_ROW_BYTES = $clog2(BW_ROW / 8 + 1);
`ifdef DCA_MATRIX_STORE_BRESP_EN
    localparam state_t S_AFTER_LAST = S_RESP;
`else
    localparam state_t S_AFTER_LAST = S_DONE;
`endif
    state_t                  state, state_nx;
    logic [BW_NUM_ROW-1:0]   rows_left;
    logic [BW_BEAT_CNT-1:0]  beat_cnt, beats_per_row, beats_nx;
    logic [BW_ROW_BYTES-1:0] row_bytes, row_bytes_nx;
    logic [BW_ROW-1:0]       row_buf;
    logic [BW_COL-1:0]       eff_col;
    logic                    last_beat, last_row;
    assign eff_col      = cmd_num_col == '0 ? BW_COL'(NUM_COL) : cmd_num_col;
    assign row_bytes_nx = BW_ROW_BYTES'(int'(eff_col) * (BW_ELEMENT / 8));
    assign beats_nx     = BW_BEAT_CNT'((int'(row_bytes_nx) + BPB - 1) / BPB);
    // rows_left counts rows not yet loaded, so zero while sending means this is the final row
    assign last_beat    = beat_cnt == beats_per_row - BW_BEAT_CNT'(1);
    assign last_row     = rows_left == '0;
    assign cmd_ready    = state == S_IDLE;
    assign wvalid       = state == S_SEND;
    assign wlast        = wvalid && last_beat && last_row;
    // the next row may only land in the buffer once the last beat of the current one has gone
    assign row_ready    = state == S_LOAD || (wvalid && wready && last_beat && !last_row);
    assign done_valid   = state == S_DONE;
    assign busy         = state != S_IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nx = cmd_num_row == '0 ? S_DONE : S_LOAD;
            S_LOAD:  if (row_valid) state_nx = S_SEND;
            S_SEND:  if (wready && last_beat) state_nx = last_row ? S_AFTER_LAST : (row_valid ? S_SEND : S_LOAD);
            S_RESP:  if (bvalid) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            rows_left     <= '0;
            beat_cnt      <= '0;
            beats_per_row <= '0;
            row_bytes     <= '0;
            row_buf       <= '0;
        end else begin
            state <= state_nx;
            if (cmd_valid && cmd_ready) begin
                rows_left     <= cmd_num_row;
                row_bytes     <= row_bytes_nx;
                beats_per_row <= beats_nx;
            end
            if (row_valid && row_ready) begin
                row_buf   <= row_data;
                beat_cnt  <= '0;
                rows_left <= rows_left - BW_NUM_ROW'(1);
            end else if (wvalid && wready) begin
                beat_cnt <= beat_cnt + BW_BEAT_CNT'(1);
            end
        end
    end
`ifdef DCA_MATRIX_STORE_BRESP_EN
    logic err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (cmd_valid && cmd_ready) err <= 1'b0;
        else if (state == S_RESP && bvalid) err <= bresp != RESP_OKAY;
    end
    assign bready     = state == S_RESP;
    assign done_error = done_valid && err;
`else
    logic unused_bresp;
    assign unused_bresp = ^bresp;
    assign bready       = 1'b1;
    assign done_error   = 1'b0;
`endif
    dca_matrix_store_beat_slicer #(
        .BW_AXI_DATA  (BW_AXI_DATA),
        .BW_ROW       (BW_ROW),
        .BW_BEAT_CNT  (BW_BEAT_CNT),
        .BW_ROW_BYTES (BW_ROW_BYTES)
    ) u_slicer (
        .row_buf   (row_buf),
        .beat_cnt  (beat_cnt),
        .row_bytes (row_bytes),
        .wdata     (wdata),
        .wstrb     (wstrb)
    );
endmodule

// File: tb/tb_dca_matrix_row_store.sv
// tb_dca_matrix_row_store: table-driven bench for the row store on a 32-bit and a 64-bit write channel
module tb_dca_matrix_row_store;
`ifdef DCA_MATRIX_STORE_BRESP_EN
    localparam bit BRESP_EN = 1'b1;
`else
    localparam bit BRESP_EN = 1'b0;
`endif
    logic clk, rst, cmd_valid_a, cmd_valid_b, row_valid, wready, bvalid, sel;
    logic [7:0] cmd_num_row;
    logic [2:0] cmd_num_col;
    logic [127:0] row_data;
    logic [1:0] bresp;
    logic cmd_ready_a, row_ready_a, wvalid_a, wlast_a, bready_a, done_valid_a, done_error_a, busy_a;
    logic cmd_ready_b, row_ready_b, wvalid_b, wlast_b, bready_b, done_valid_b, done_error_b, busy_b;
    logic [31:0] wdata_a;
    logic [3:0] wstrb_a;
    logic [63:0] wdata_b;
    logic [7:0] wstrb_b;
    logic cmd_ready, row_ready, wvalid, wlast, bready, done_valid, done_error, busy;
    logic [63:0] wdata;
    logic [7:0] wstrb;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dca_matrix_row_store u_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_num_row(cmd_num_row), .cmd_num_col(cmd_num_col),
        .row_valid(row_valid), .row_ready(row_ready_a), .row_data(row_data),
        .wvalid(wvalid_a), .wready(wready), .wdata(wdata_a), .wstrb(wstrb_a), .wlast(wlast_a),
        .bvalid(bvalid), .bready(bready_a), .bresp(bresp),
        .done_valid(done_valid_a), .done_error(done_error_a), .busy(busy_a)
    );
    dca_matrix_row_store #(.BW_AXI_DATA(64)) u_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_num_row(cmd_num_row), .cmd_num_col(cmd_num_col),
        .row_valid(row_valid), .row_ready(row_ready_b), .row_data(row_data),
        .wvalid(wvalid_b), .wready(wready), .wdata(wdata_b), .wstrb(wstrb_b), .wlast(wlast_b),
        .bvalid(bvalid), .bready(bready_b), .bresp(bresp),
        .done_valid(done_valid_b), .done_error(done_error_b), .busy(busy_b)
    );

    always_comb begin
        cmd_ready  = sel ? cmd_ready_b : cmd_ready_a;
        row_ready  = sel ? row_ready_b : row_ready_a;
        wvalid     = sel ? wvalid_b : wvalid_a;
        wlast      = sel ? wlast_b : wlast_a;
        bready     = sel ? bready_b : bready_a;
        done_valid = sel ? done_valid_b : done_valid_a;
        done_error = sel ? done_error_b : done_error_a;
        busy       = sel ? busy_b : busy_a;
        wdata      = sel ? wdata_b : {32'b0, wdata_a};
        wstrb      = sel ? wstrb_b : {4'b0, wstrb_a};
    end

    typedef struct {
        bit s;
        int num_row;
        int num_col;
        logic [1:0] br;
        bit stall;
        int exp_beats;
        bit exp_err_en;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // element c of row r is 0x11*(4r+c+1): row 0 = 0x44..0x11, row 1 = 0x88..0x55
    function automatic logic [127:0] row_of(input int r);
        logic [127:0] v;
        for (int c = 0; c < 4; c++) v[c*32 +: 32] = 32'(17 * (4 * r + c + 1));
        return v;
    endfunction

    function automatic logic [71:0] exp_beat(input bit s, input int r, input int k, input int eff);
        int w = s ? 64 : 32;
        int bpb = w / 8;
        int n = eff * 4 - k * bpb;
        logic [127:0] sh = row_of(r) >> (k * w);
        logic [63:0] d = s ? sh[63:0] : {32'b0, sh[31:0]};
        n = n > bpb ? bpb : n;
        return {8'((1 << n) - 1), d};
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_row_ready"}, row_ready, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_wstrb"}, 64'(wstrb), 0);
        chk({tag, "_done_valid"}, done_valid, 0);
        chk({tag, "_done_error"}, done_error, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bready"}, bready, BRESP_EN ? 0 : 1);
    endtask

    task automatic run_vec(input vec_t v, input int abort_at);
        int eff = v.num_col == 0 ? 4 : v.num_col;
        int bpb = v.s ? 8 : 4;
        int bpr = (eff * 4 + bpb - 1) / bpb;
        int total = v.num_row * bpr;
        int beat = 0, rows_sent = 0, trig = 0, done_cyc = -1, first_w = -1;
        int bubbles = 0, unstable = 0, bready_bad = 0;
        bit resp_phase = 0, held = 0, got_err = 0;
        logic [63:0] hd;
        logic [7:0] hs;
        logic hl;
        logic [71:0] e;
        sel = v.s;
        @(negedge clk);
        cmd_num_row = 8'(v.num_row);
        cmd_num_col = 3'(v.num_col);
        bresp = v.br;
        if (v.s) cmd_valid_b = 1'b1;
        else cmd_valid_a = 1'b1;
        #1;
        chk("cmd_ready", cmd_ready, 1);
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk);
            cmd_valid_a = 1'b0;
            cmd_valid_b = 1'b0;
            if (cyc == 1 && v.num_row != 0) chk("cmd_to_row_ready", row_ready, 1);
            wready = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            row_valid = rows_sent < v.num_row && (v.stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            row_data = row_of(rows_sent);
            bvalid = resp_phase && (v.stall ? ($urandom_range(0, 1) != 0) : 1'b1);
            #1;
            if (abort_at >= 0 && beat == abort_at && wvalid) begin
                rst = 1'b1;
                return;
            end
            if (bready !== (BRESP_EN ? resp_phase : 1'b1)) bready_bad++;
            if (held && (!wvalid || wdata !== hd || wstrb !== hs || wlast !== hl)) unstable++;
            held = wvalid && !wready;
            hd = wdata;
            hs = wstrb;
            hl = wlast;
            if (first_w >= 0 && !wvalid && beat < total) bubbles++;
            if (wvalid && wready) begin
                if (beat < total) begin
                    e = exp_beat(v.s, beat / bpr, beat % bpr, eff);
                    chk("wdata", wdata, e[63:0]);
                    chk("wstrb", 64'(wstrb), 64'(e[71:64]));
                    chk("wlast", wlast, beat == total - 1);
                end
                beat++;
                if (wlast) begin
                    resp_phase = BRESP_EN;
                    if (!BRESP_EN) trig = cyc;
                end
            end
            if (bvalid && bready && resp_phase) begin
                resp_phase = 0;
                trig = cyc;
            end
            if (row_valid && row_ready) begin
                rows_sent++;
                if (first_w < 0) first_w = cyc;
            end
            if (done_valid) begin
                done_cyc = cyc;
                got_err = done_error;
                break;
            end
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        chk("beats", beat, v.exp_beats);
        chk("rows", rows_sent, v.num_row);
        chk("done_latency", done_cyc - trig, 1);
        chk("done_error", got_err, v.exp_err_en & BRESP_EN);
        chk("bready", bready_bad, 0);
        chk("stable", unstable, 0);
        if (!v.stall) chk("bubbles", bubbles, 0);
        @(negedge clk);
        row_valid = 1'b0;
        bvalid = 1'b0;
        #1;
        chk("done_pulse", done_valid, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
        row_valid = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
        cmd_num_row = '0;
        cmd_num_col = '0;
        row_data = '0;
        bresp = '0;
        tbl[0] = '{0, 2, 4, 2'b00, 0, 8, 0};
        tbl[1] = '{1, 1, 3, 2'b00, 0, 2, 0};
        tbl[2] = '{0, 16, 4, 2'b00, 1, 64, 0};
        tbl[3] = '{0, 0, 4, 2'b00, 0, 0, 0};
        tbl[4] = '{0, 1, 1, 2'b10, 0, 1, 1};
        tbl[5] = '{1, 3, 0, 2'b00, 1, 6, 0};
        tbl[6] = '{0, 2, 2, 2'b11, 1, 4, 1};
        tbl[7] = '{1, 2, 1, 2'b00, 0, 2, 0};
        #2;
        check_reset("por");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) run_vec(tbl[i], -1);
        run_vec(tbl[0], 2);
        #1;
        sel = 1'b0;
        #1;
        check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        row_valid = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
        cmd_valid_a = 1'b0;
        run_vec(tbl[0], -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
